alu_operand_sequencer: RTL

// Upstream/downstream wrapper stage for the 8-bit combinational ALU: collects A, B and OP as three

---
 rtl/alu_operand_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_sequencer
// Description : Gathers operand A, operand B and the opcode as three beats on
//               a narrow valid/ready input bus, presents them to an external
//               combinational ALU from registers, and holds the ALU result in
//               an output register until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNTW-1:0]  res_count
);

    // Sequencer states: three collection beats, one settle cycle, one hold.
    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [CNTW-1:0]  r_res_count;

    logic w_collecting;
    logic w_beat;
    logic w_handoff;

    // Beats are only taken while collecting; flush blocks acceptance so a
    // beat presented alongside an abort is never half-consumed.
    always_comb begin
        w_collecting = (r_state == S_A) || (r_state == S_B) || (r_state == S_OP);
        in_ready     = w_collecting && !flush && !rst;
        w_beat       = in_valid && in_ready;
        w_handoff    = r_out_valid && out_ready;
    end

    // Main sequencer: operand capture, result capture and handoff counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_A;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_res_count <= '0;
        end else if (flush) begin
            // Abort: operand/result registers deliberately keep their values.
            r_state     <= S_A;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_beat) begin
                        r_alu_a <= in_data;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_beat) begin
                        r_alu_b <= in_data;
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    if (w_beat) begin
                        r_alu_op <= in_data[OPW-1:0];
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for a full cycle; sample result.
                    r_out_data  <= alu_result;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (w_handoff) begin
                        r_out_valid <= 1'b0;
                        r_res_count <= r_res_count + 1'b1;
                        r_state     <= S_A;
                    end
                end
                default: begin
                    r_state     <= S_A;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output drive straight from registers.
    always_comb begin
        alu_a     = r_alu_a;
        alu_b     = r_alu_b;
        alu_op    = r_alu_op;
        out_data  = r_out_data;
        out_valid = r_out_valid;
        res_count = r_res_count;
        busy      = (r_state != S_A);
    end

endmodule
`default_nettype wire
